// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - HI/LO multiply/divide sequencer for the E stage
// Decodes HI/LO instructions, runs MULT/DIV on a down-counter and commits HI/LO.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic [31:0] rs_valE,
  input  logic [31:0] rt_valE,
  output logic        busy,
  output logic        stall_md,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        md_done_q, md_done_d;

  logic [5:0]  funct_d, funct_e;
  logic        special_d, special_e;
  logic        md_D, start_E, mthi_E, mtlo_E;

  assign special_d = (instrD[31:26] == 6'd0);
  assign special_e = (instrE[31:26] == 6'd0);
  assign funct_d   = instrD[5:0];
  assign funct_e   = instrE[5:0];

  // 0x10..0x13 are MFHI/MTHI/MFLO/MTLO, 0x18..0x1B are MULT/MULTU/DIV/DIVU
  assign md_D    = special_d && (funct_d[5:2] == 4'b0100 || funct_d[5:2] == 4'b0110);
  assign start_E = special_e && (funct_e[5:2] == 4'b0110);
  assign mthi_E  = special_e && (funct_e == F_MTHI);
  assign mtlo_E  = special_e && (funct_e == F_MTLO);

  assign stall_md = md_D && ((state_q == S_RUN) || start_E);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic        [31:0] res_hi, res_lo;
  logic               div_zero, div_ovf;

  assign prod_s   = $signed({{32{rs_valE[31]}}, rs_valE}) * $signed({{32{rt_valE[31]}}, rt_valE});
  assign prod_u   = {32'd0, rs_valE} * {32'd0, rt_valE};
  assign quo_s    = $signed(rs_valE) / $signed(rt_valE);
  assign rem_s    = $signed(rs_valE) % $signed(rt_valE);
  assign quo_u    = rs_valE / rt_valE;
  assign rem_u    = rs_valE % rt_valE;
  assign div_zero = (rt_valE == 32'd0);
  assign div_ovf  = (rs_valE == 32'h8000_0000) && (rt_valE == 32'hFFFF_FFFF);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (funct_e[1:0])
      2'b00: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'b01: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'b10: begin
        if (div_zero) begin
          res_hi = rs_valE;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      default: begin
        if (div_zero) begin
          res_hi = rs_valE;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmp_hi_d  = tmp_hi_q;
    tmp_lo_d  = tmp_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    md_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_E) begin
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          cnt_d    = funct_e[1] ? DIV_LOAD : MULT_LOAD;
          state_d  = S_RUN;
        end else begin
          if (mthi_E) hi_d = rs_valE;
          if (mtlo_E) lo_d = rs_valE;
        end
      end
      default: begin
        // HI/LO instructions reaching E here are ignored; the stall should prevent them
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d      = tmp_hi_q;
          lo_d      = tmp_lo_q;
          md_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      tmp_hi_q  <= 32'd0;
      tmp_lo_q  <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmp_hi_q  <= tmp_hi_d;
      tmp_lo_q  <= tmp_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      md_done_q <= md_done_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign md_done = md_done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
